// File: rtl/clk_div_pkg.sv
// Shared constants, status struct and TC helper for the programmable clock dividers.
package clk_div_pkg;

    localparam int CTR_W  = 23;
    localparam int CLK_HZ = 100_000_000;
    localparam logic [CTR_W-1:0] DEFAULT_TC = 23'd4_999_999;

    typedef struct packed {
        logic clk_out;
        logic tick;
        logic pending;
    } ch_stat_t;

    // Terminal count for a square wave of hz Hz; hz must be non-zero.
    function automatic logic [CTR_W-1:0] tc_for(input int unsigned hz);
        return CTR_W'(CLK_HZ / (2 * hz) - 1);
    endfunction

endpackage

// File: rtl/clk_div_channel.sv
// One divider channel: counter, active/shadow TC and tick; registered outputs.
// A TC write lands in the shadow and is applied only at a wrap, a sync or while disabled.
module clk_div_channel #(
    parameter int CTR_W = clk_div_pkg::CTR_W,
    parameter logic [CTR_W-1:0] DEFAULT_TC = clk_div_pkg::DEFAULT_TC
) (
    input  logic             clk_100MHz,
    input  logic             reset,
    input  logic             en,
    input  logic             sync,
    input  logic             wr,
    input  logic [CTR_W-1:0] wr_tc,
    output clk_div_pkg::ch_stat_t stat
);
    import clk_div_pkg::*;

    logic [CTR_W-1:0] ctr;
    logic [CTR_W-1:0] tc;
    logic [CTR_W-1:0] shadow;
    logic             clk_q;
    logic             tick_q;
    logic             pending_q;
    logic             wrap;
    logic             apply;

    // ">=" keeps a channel from hanging if ctr ever exceeds tc.
    assign wrap  = (ctr >= tc);
    assign apply = pending_q & (~en | sync | wrap);

    always_ff @(posedge clk_100MHz or posedge reset) begin
        if (reset) begin
            ctr       <= '0;
            tc        <= DEFAULT_TC;
            shadow    <= DEFAULT_TC;
            clk_q     <= 1'b0;
            tick_q    <= 1'b0;
            pending_q <= 1'b0;
        end else begin
            if (!en || sync) begin
                ctr    <= '0;
                clk_q  <= 1'b0;
                tick_q <= 1'b0;
            end else if (wrap) begin
                ctr    <= '0;
                clk_q  <= ~clk_q;
                tick_q <= 1'b1;
            end else begin
                ctr    <= ctr + 1'b1;
                tick_q <= 1'b0;
            end
            // wr is only issued while nothing is pending, so it never collides with apply.
            if (wr) begin
                shadow    <= wr_tc;
                pending_q <= 1'b1;
            end else if (apply) begin
                tc        <= shadow;
                pending_q <= 1'b0;
            end
        end
    end

    assign stat = '{clk_out: clk_q, tick: tick_q, pending: pending_q};

endmodule

// File: rtl/multi_clk_div.sv
// Multi-channel programmable divider: cfg_ch decode, cfg_ready mux and sync fan-out.
// Fabric enables only; clk_out must not drive clock nets.
module multi_clk_div #(
    parameter int NUM_CH = 4,
    parameter int CTR_W  = clk_div_pkg::CTR_W,
    parameter logic [CTR_W-1:0] DEFAULT_TC = clk_div_pkg::DEFAULT_TC,
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              clk_100MHz,
    input  logic              reset,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic              sync,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [CTR_W-1:0]  cfg_tc,
    output logic [NUM_CH-1:0] clk_out,
    output logic [NUM_CH-1:0] tick,
    output logic [NUM_CH-1:0] pending
);
    import clk_div_pkg::*;

    ch_stat_t stat [NUM_CH];
    logic     accept;

    // Out-of-range channels are always ready; their writes are dropped.
    always_comb begin
        cfg_ready = 1'b1;
        for (int i = 0; i < NUM_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                cfg_ready = ~pending[i];
            end
        end
    end

    assign accept = cfg_valid & cfg_ready;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        clk_div_channel #(
            .CTR_W      (CTR_W),
            .DEFAULT_TC (DEFAULT_TC)
        ) u_ch (
            .clk_100MHz (clk_100MHz),
            .reset      (reset),
            .en         (ch_en[g]),
            .sync       (sync),
            .wr         (accept && (cfg_ch == CH_W'(g))),
            .wr_tc      (cfg_tc),
            .stat       (stat[g])
        );
        assign clk_out[g] = stat[g].clk_out;
        assign tick[g]    = stat[g].tick;
        assign pending[g] = stat[g].pending;
    end

endmodule

// File: tb/tb_multi_clk_div.sv
// Bench for multi_clk_div with 4 channels and a reset TC of 4.
module tb_multi_clk_div;

    localparam int NUM_CH = 4;
    localparam int CTR_W  = 23;
    localparam int TC0    = 4;

    logic              clk_100MHz = 1'b0;
    logic              reset      = 1'b1;
    logic [NUM_CH-1:0] ch_en      = '1;
    logic              sync       = 1'b0;
    logic              cfg_valid  = 1'b0;
    logic              cfg_ready;
    logic [1:0]        cfg_ch     = '0;
    logic [CTR_W-1:0]  cfg_tc     = '0;
    logic [NUM_CH-1:0] clk_out;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] pending;

    int errors = 0;
    int checks = 0;

    // Reference model: elapsed enabled cycles since the last restart, plus active/shadow TC.
    int m_tc   [NUM_CH];
    int m_sh   [NUM_CH];
    int m_ph   [NUM_CH];
    bit m_clk  [NUM_CH];
    bit m_tick [NUM_CH];
    bit m_pend [NUM_CH];

    multi_clk_div #(
        .NUM_CH     (NUM_CH),
        .CTR_W      (CTR_W),
        .DEFAULT_TC (23'(TC0))
    ) dut (
        .clk_100MHz (clk_100MHz),
        .reset      (reset),
        .ch_en      (ch_en),
        .sync       (sync),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_tc     (cfg_tc),
        .clk_out    (clk_out),
        .tick       (tick),
        .pending    (pending)
    );

    always #5 clk_100MHz = ~clk_100MHz;

    function automatic void m_reset();
        for (int c = 0; c < NUM_CH; c++) begin
            m_tc[c] = TC0; m_sh[c] = TC0; m_ph[c] = 0;
            m_clk[c] = 0; m_tick[c] = 0; m_pend[c] = 0;
        end
    endfunction

    function automatic logic [11:0] m_vec();
        logic [3:0] c, t, p;
        for (int i = 0; i < NUM_CH; i++) begin
            c[i] = m_clk[i]; t[i] = m_tick[i]; p[i] = m_pend[i];
        end
        return {c, t, p};
    endfunction

    function automatic logic m_ready();
        return !m_pend[int'(cfg_ch)];
    endfunction

    // One clock: the model consumes the inputs present at the edge, outputs are sampled 1 ns later.
    task automatic step();
        bit acc [NUM_CH];
        @(posedge clk_100MHz);
        if (!reset) begin
            for (int c = 0; c < NUM_CH; c++) begin
                acc[c] = cfg_valid && (int'(cfg_ch) == c) && !m_pend[c];
                if (!ch_en[c] || sync) begin
                    m_ph[c] = 0; m_clk[c] = 0; m_tick[c] = 0;
                    if (m_pend[c]) begin m_tc[c] = m_sh[c]; m_pend[c] = 0; end
                end else begin
                    m_ph[c]++;
                    if (m_ph[c] == m_tc[c] + 1) begin
                        m_ph[c] = 0; m_clk[c] = !m_clk[c]; m_tick[c] = 1;
                        if (m_pend[c]) begin m_tc[c] = m_sh[c]; m_pend[c] = 0; end
                    end else begin
                        m_tick[c] = 0;
                    end
                end
                if (acc[c]) begin m_sh[c] = int'(cfg_tc); m_pend[c] = 1; end
            end
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; ch_en = '1; sync = 0; cfg_valid = 0; cfg_ch = 0; cfg_tc = 0;
        m_reset();
        #3;
        checks++;
        if ({clk_out, tick, pending} !== 12'h000) begin
            errors++; $display("FAIL reset_outputs got=%h exp=%h", {clk_out, tick, pending}, 12'h000);
        end
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++; $display("FAIL reset_cfg_ready got=%b exp=1", cfg_ready);
        end
        @(posedge clk_100MHz); #1;
        reset = 1'b0;
    endtask

    task automatic test_default_toggle();
        logic [3:0] exp_t, exp_c;
        for (int cyc = 1; cyc <= 16; cyc++) begin
            step();
            exp_t = (cyc % 5 == 0) ? 4'hF : 4'h0;
            exp_c = ((cyc / 5) % 2 == 1) ? 4'hF : 4'h0;
            checks++;
            if (tick !== exp_t || clk_out !== exp_c) begin
                errors++;
                $display("FAIL default_toggle cyc=%0d got clk=%h tick=%h exp clk=%h tick=%h", cyc, clk_out, tick, exp_c, exp_t);
            end
            checks++;
            if ({clk_out, tick, pending} !== m_vec()) begin
                errors++; $display("FAIL default_model cyc=%0d got=%h exp=%h", cyc, {clk_out, tick, pending}, m_vec());
            end
        end
    endtask

    task automatic test_cfg_write();
        int n, ticks;
        step(); step();
        cfg_valid = 1; cfg_ch = 1; cfg_tc = 23'd1;
        #1;
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++; $display("FAIL write_ready got=%b exp=1", cfg_ready);
        end
        step();
        cfg_valid = 0;
        checks++;
        if (pending[1] !== 1'b1) begin
            errors++; $display("FAIL write_pending got=%b exp=1", pending[1]);
        end
        n = 0;
        while (m_pend[1] && n < 12) begin
            checks++;
            if (cfg_ready !== 1'b0) begin
                errors++; $display("FAIL write_busy_ready got=%b exp=0", cfg_ready);
            end
            step(); n++;
            checks++;
            if ({clk_out, tick, pending} !== m_vec()) begin
                errors++; $display("FAIL write_model got=%h exp=%h", {clk_out, tick, pending}, m_vec());
            end
        end
        checks++;
        if (pending[1] !== 1'b0) begin
            errors++; $display("FAIL write_apply_timeout got pending=%b exp=0", pending[1]);
        end
        ticks = 0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (tick[1] === 1'b1) ticks++;
            checks++;
            if ({clk_out, tick, pending} !== m_vec()) begin
                errors++; $display("FAIL write_after_model got=%h exp=%h", {clk_out, tick, pending}, m_vec());
            end
        end
        checks++;
        if (ticks != 4) begin
            errors++; $display("FAIL write_period ch1 ticks in 8 cycles got=%0d exp=4", ticks);
        end
    endtask

    task automatic test_double_write();
        int n, ticks;
        cfg_valid = 1; cfg_ch = 3; cfg_tc = 23'd2;
        step();
        cfg_tc = 23'd7;
        #1;
        checks++;
        if (cfg_ready !== 1'b0) begin
            errors++; $display("FAIL double_ready got=%b exp=0", cfg_ready);
        end
        step();
        cfg_valid = 0;
        n = 0;
        while (pending[3] === 1'b1 && n < 12) begin step(); n++; end
        checks++;
        if (pending[3] !== 1'b0) begin
            errors++; $display("FAIL double_apply_timeout got pending=%b exp=0", pending[3]);
        end
        ticks = 0;
        for (int i = 0; i < 9; i++) begin
            step();
            if (tick[3] === 1'b1) ticks++;
        end
        checks++;
        if (ticks != 3) begin
            errors++; $display("FAIL double_shadow ch3 ticks in 9 cycles got=%0d exp=3", ticks);
        end
        checks++;
        if ({clk_out, tick, pending} !== m_vec()) begin
            errors++; $display("FAIL double_model got=%h exp=%h", {clk_out, tick, pending}, m_vec());
        end
    endtask

    task automatic test_disable();
        int n;
        n = 0;
        while (m_ph[2] != 3 && n < 12) begin step(); n++; end
        ch_en[2] = 1'b0;
        step();
        checks++;
        if (clk_out[2] !== 1'b0 || tick[2] !== 1'b0) begin
            errors++; $display("FAIL disable got clk=%b tick=%b exp clk=0 tick=0", clk_out[2], tick[2]);
        end
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if ({clk_out, tick, pending} !== m_vec()) begin
                errors++; $display("FAIL disable_model got=%h exp=%h", {clk_out, tick, pending}, m_vec());
            end
        end
        ch_en[2] = 1'b1;
        n = 0;
        do begin step(); n++; end while (tick[2] !== 1'b1 && n < 12);
        checks++;
        if (n != 5 || clk_out[2] !== 1'b1) begin
            errors++; $display("FAIL reenable first toggle got=%0d cycles clk=%b exp=5 cycles clk=1", n, clk_out[2]);
        end
    endtask

    task automatic test_sync();
        int tcs [NUM_CH] = '{3, 1, 4, 2};
        logic [3:0] exp_t;
        cfg_valid = 1; cfg_ch = 0; cfg_tc = 23'd3;
        #1;
        checks++;
        if (cfg_ready !== 1'b1) begin
            errors++; $display("FAIL sync_write_ready got=%b exp=1", cfg_ready);
        end
        step();
        cfg_valid = 0; sync = 1;
        step();
        sync = 0;
        checks++;
        if ({clk_out, tick, pending} !== 12'h000) begin
            errors++; $display("FAIL sync_realign got=%h exp=000", {clk_out, tick, pending});
        end
        for (int k = 1; k <= 12; k++) begin
            step();
            for (int c = 0; c < NUM_CH; c++) exp_t[c] = (k % (tcs[c] + 1) == 0);
            checks++;
            if (tick !== exp_t) begin
                errors++; $display("FAIL sync_ticks k=%0d got=%h exp=%h", k, tick, exp_t);
            end
            checks++;
            if ({clk_out, tick, pending} !== m_vec()) begin
                errors++; $display("FAIL sync_model k=%0d got=%h exp=%h", k, {clk_out, tick, pending}, m_vec());
            end
        end
    endtask

    task automatic test_reset_pending();
        int n;
        n = 0;
        while (clk_out[0] !== 1'b1 && n < 10) begin step(); n++; end
        cfg_valid = 1; cfg_ch = 0; cfg_tc = 23'd6;
        step();
        cfg_valid = 0;
        checks++;
        if (pending[0] !== 1'b1 || clk_out[0] !== 1'b1) begin
            errors++; $display("FAIL rst_setup got pending=%b clk=%b exp pending=1 clk=1", pending[0], clk_out[0]);
        end
        #2;
        reset = 1'b1;
        m_reset();
        #1;
        checks++;
        if ({clk_out, tick, pending} !== 12'h000) begin
            errors++; $display("FAIL rst_async got=%h exp=000", {clk_out, tick, pending});
        end
        @(posedge clk_100MHz); #1;
        reset = 1'b0;
        for (int k = 1; k <= 5; k++) step();
        checks++;
        if (tick !== 4'hF || clk_out !== 4'hF || pending !== 4'h0) begin
            errors++; $display("FAIL rst_tc_default got clk=%h tick=%h pend=%h exp clk=F tick=F pend=0", clk_out, tick, pending);
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            ch_en     = ($urandom_range(0, 7) == 0) ? 4'($urandom) : 4'hF;
            sync      = ($urandom_range(0, 39) == 0);
            cfg_valid = ($urandom_range(0, 3) == 0);
            cfg_ch    = 2'($urandom_range(0, 3));
            cfg_tc    = 23'($urandom_range(0, 5));
            #1;
            checks++;
            if (cfg_ready !== m_ready()) begin
                errors++; $display("FAIL rand_ready i=%0d got=%b exp=%b", i, cfg_ready, m_ready());
            end
            step();
            checks++;
            if ({clk_out, tick, pending} !== m_vec()) begin
                errors++; $display("FAIL rand_model i=%0d got=%h exp=%h", i, {clk_out, tick, pending}, m_vec());
            end
        end
        ch_en = '1; sync = 0; cfg_valid = 0;
    endtask

    initial begin
        #200_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_default_toggle();
        test_cfg_write();
        test_double_write();
        test_disable();
        test_sync();
        test_reset_pending();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
